// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and width helpers.
package alu_pkg;

  localparam int unsigned N_DEF   = 32;
  localparam int unsigned OPW_DEF = 4;
  localparam int unsigned SHW     = $clog2(N_DEF);

  typedef enum logic [OPW_DEF-1:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SLL   = 4'd3,
    OP_XOR   = 4'd4,
    OP_SRL   = 4'd5,
    OP_SUB   = 4'd6,
    OP_SLT   = 4'd7,
    OP_SRA   = 4'd8,
    OP_MUL   = 4'd9,
    OP_MULHU = 4'd10,
    OP_DIVU  = 4'd11,
    OP_REMU  = 4'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // True for the op codes handled by the iterative multiply/divide unit.
  function automatic logic is_muldiv(input logic [OPW_DEF-1:0] op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per cycle.
// The start cycle already performs step 1 on the incoming operands, so done pulses n-1 cycles later.
module alu_muldiv_iter #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic         want_hi,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CW = $clog2(N) + 1;

  logic [N-1:0]  hi_q, hi_d, lo_q, lo_d, m_q, m_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, div_q, div_d, sel_q, sel_d, done_q, done_d;

  // Current step operands: fresh from the ports on start, from the registers otherwise.
  logic [N-1:0] cur_hi, cur_lo, cur_m;
  logic         cur_div;
  logic [N:0]   add_c, mul_sum;
  logic [N:0]   shifted;
  logic [N-1:0] diff;
  logic         ge;
  logic [N-1:0] step_hi, step_lo;

  always_comb begin
    cur_hi  = start ? '0 : hi_q;
    cur_lo  = start ? (is_div ? a : b) : lo_q;
    cur_m   = start ? (is_div ? b : a) : m_q;
    cur_div = start ? is_div : div_q;

    add_c   = {1'b0, cur_hi} + {1'b0, cur_m};
    mul_sum = cur_lo[0] ? add_c : {1'b0, cur_hi};

    shifted = {cur_hi, cur_lo[N-1]};
    diff    = shifted[N-1:0] - cur_m;
    ge      = (shifted >= {1'b0, cur_m});

    if (cur_div) begin
      step_hi = ge ? diff : shifted[N-1:0];
      step_lo = {cur_lo[N-2:0], ge};
    end else begin
      step_hi = mul_sum[N:1];
      step_lo = {mul_sum[0], cur_lo[N-1:1]};
    end
  end

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    div_d    = div_q;
    sel_d    = sel_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (start) begin
      hi_d   = step_hi;
      lo_d   = step_lo;
      m_d    = cur_m;
      div_d  = is_div;
      sel_d  = want_hi;
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(N - 1)) begin
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = sel_q ? step_hi : step_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      div_q    <= 1'b0;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      div_q    <= div_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle simple ops, optional iterative MUL/DIV.
// Build option: define ALU_SEQ_MULDIV_EN to enable ops 9-12 (otherwise they are illegal).
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned n   = N_DEF,
  parameter int unsigned OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic [OPW-1:0] op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [n-1:0]   r,
  output logic           zero,
  output logic           ovf,
  output logic           illegal
);

  localparam int unsigned SHAMT_W = $clog2(n);

  alu_state_t   state_q, state_d;
  logic [n-1:0] r_q, r_d;
  logic         zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
  logic         out_valid_q, out_valid_d, in_ready_q, in_ready_d;
  logic         accept_c;

  logic [n-1:0]       res_c, sum_c, b_neg_c;
  logic               res_ovf_c, res_ill_c;
  logic [SHAMT_W-1:0] shamt_c;

  assign accept_c = in_valid && in_ready_q;

  // Single-cycle datapath evaluated directly on the operands being accepted.
  always_comb begin
    res_c     = '0;
    res_ovf_c = 1'b0;
    res_ill_c = 1'b0;
    sum_c     = '0;
    b_neg_c   = ~b + n'(1);
    shamt_c   = b[SHAMT_W-1:0];
    case (op)
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_XOR: res_c = a ^ b;
      OP_ADD: begin
        sum_c     = a + b;
        res_c     = sum_c;
        res_ovf_c = (a[n-1] == b[n-1]) && (sum_c[n-1] != a[n-1]);
      end
      OP_SUB: begin
        sum_c     = a + b_neg_c;
        res_c     = sum_c;
        res_ovf_c = (a[n-1] == b_neg_c[n-1]) && (sum_c[n-1] != a[n-1]);
      end
      OP_SLT: res_c = {{(n-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: res_c = a << shamt_c;
      OP_SRL: res_c = a >> shamt_c;
      OP_SRA: res_c = $unsigned($signed(a) >>> shamt_c);
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: res_c = '0;
`endif
      default: res_ill_c = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic         md_start_c;
  logic         md_done;
  logic [n-1:0] md_result;

  alu_muldiv_iter #(
    .N(n)
  ) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start_c),
    .is_div  ((op == OP_DIVU) || (op == OP_REMU)),
    .want_hi ((op == OP_MULHU) || (op == OP_REMU)),
    .a       (a),
    .b       (b),
    .done    (md_done),
    .result  (md_result)
  );
`endif

  // Control FSM and output register next-state.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
`ifdef ALU_SEQ_MULDIV_EN
    md_start_c = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = DONE;
          r_d     = res_c;
          zero_d  = (res_c == '0);
          ovf_d   = res_ovf_c;
          ill_d   = res_ill_c;
`ifdef ALU_SEQ_MULDIV_EN
          if (is_muldiv(op)) begin
            state_d    = BUSY;
            md_start_c = 1'b1;
          end
`endif
        end
      end
`ifdef ALU_SEQ_MULDIV_EN
      BUSY: begin
        if (md_done) begin
          state_d = DONE;
          r_d     = md_result;
          zero_d  = (md_result == '0);
          ovf_d   = 1'b0;
          ill_d   = 1'b0;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      r_q         <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake corner cases, random ops vs model.
module tb_alu_seq;

  localparam int N = 32;

`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [3:0] T_AND = 4'd0, T_OR = 4'd1, T_ADD = 4'd2, T_SLL = 4'd3, T_XOR = 4'd4,
                         T_SRL = 4'd5, T_SUB = 4'd6, T_SLT = 4'd7, T_SRA = 4'd8, T_MUL = 4'd9,
                         T_MULHU = 4'd10, T_DIVU = 4'd11, T_REMU = 4'd12;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  a, b, r;
  logic [3:0]    op;
  logic          zero, ovf, illegal;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.n(N), .OPW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .zero(zero), .ovf(ovf), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] r;
    logic         z;
    logic         o;
    logic         il;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic bit is_md(input logic [3:0] o);
    return (o >= 4'd9) && (o <= 4'd12);
  endfunction

  // Reference behaviour written straight from the operation definitions.
  task automatic model(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                       output logic [N-1:0] er, output logic ez, output logic eo, output logic eil);
    logic [63:0]  p;
    logic [N-1:0] yn;
    int           sh;
    p   = 64'(x) * 64'(y);
    yn  = -y;
    sh  = int'(y[4:0]);
    er  = '0;
    eo  = 1'b0;
    eil = (o > 4'd12) || (is_md(o) && !MD_EN);
    if (!eil) begin
      case (o)
        T_AND:   er = x & y;
        T_OR:    er = x | y;
        T_XOR:   er = x ^ y;
        T_ADD: begin er = x + y; eo = (x[N-1] == y[N-1])  && (er[N-1] != x[N-1]); end
        T_SUB: begin er = x - y; eo = (x[N-1] == yn[N-1]) && (er[N-1] != x[N-1]); end
        T_SLT:   er = ($signed(x) < $signed(y)) ? 1 : 0;
        T_SLL:   er = x << sh;
        T_SRL:   er = x >> sh;
        T_SRA:   er = $unsigned($signed(x) >>> sh);
        T_MUL:   er = p[31:0];
        T_MULHU: er = p[63:32];
        T_DIVU:  er = (y == 0) ? '1 : x / y;
        T_REMU:  er = (y == 0) ? x : x % y;
        default: er = '0;
      endcase
    end
    ez = (er == 0);
  endtask

  // Bounded wait for in_ready, sampling 1 time unit after the rising edge.
  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [3:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        output logic [N-1:0] gr, output logic gz, output logic go,
                        output logic gil, output int lat);
    wait_ready();
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    gr = r; gz = zero; go = ovf; gil = illegal;
  endtask

  task automatic run_and_check(input string nm, input logic [3:0] o, input logic [N-1:0] x,
                               input logic [N-1:0] y, input logic [N-1:0] er, input logic ez,
                               input logic eo, input logic eil);
    logic [N-1:0] gr;
    logic         gz, go, gil;
    int           lat, elat;
    elat = (is_md(o) && MD_EN) ? N + 1 : 1;
    run_op(o, x, y, gr, gz, go, gil, lat);
    chk({nm, "_lat"}, 64'(lat), 64'(elat));
    chk({nm, "_r"},   64'(gr),  64'(er));
    chk({nm, "_z"},   64'(gz),  64'(ez));
    chk({nm, "_ovf"}, 64'(go),  64'(eo));
    chk({nm, "_ill"}, 64'(gil), 64'(eil));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] er;
    logic         ez, eo, eil, seen;
    logic [3:0]   ro;
    logic [N-1:0] ra, rb;

    tbl.push_back('{T_ADD, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{T_SUB, 32'h5,         32'h5,         32'h0,         1'b1, 1'b0, 1'b0});
    tbl.push_back('{T_SLT, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_SRA, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_SRL, 32'h8000_0000, 32'd31,        32'h1,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_SLL, 32'h1,         32'd36,        32'h10,        1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_AND, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_OR,  32'hF0F0,      32'hFF00,      32'hFFF0,      1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_XOR, 32'hFF,        32'h0F,        32'hF0,        1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_SUB, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{4'd13, 32'h1234,      32'h5678,      32'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{4'd15, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b0, 1'b1});
`ifdef ALU_SEQ_MULDIV_EN
    tbl.push_back('{T_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_DIVU,  32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_REMU,  32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_DIVU,  32'd12345,     32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{T_REMU,  32'd9,         32'd0,         32'd9,         1'b0, 1'b0, 1'b0});
`else
    tbl.push_back('{T_DIVU,  32'd100,       32'd7,         32'h0,         1'b1, 1'b0, 1'b1});
    tbl.push_back('{T_MUL,   32'd3,         32'd4,         32'h0,         1'b1, 1'b0, 1'b1});
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_r",         64'(r),         64'd0);
    chk("rst_zero",      64'(zero),      64'd1);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_illegal",   64'(illegal),   64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    foreach (tbl[i])
      run_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                    tbl[i].r, tbl[i].z, tbl[i].o, tbl[i].il);

    // Backpressure: result must hold while the consumer stalls.
    wait_ready();
    out_ready = 1'b0;
    in_valid = 1'b1; op = T_ADD; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'd100; b = 32'd200;
    for (int c = 0; c < 5; c++) begin
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_r",         64'(r),         64'd7);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_release_in_ready",  64'(in_ready),  64'd1);

    // Abort an operation in flight with reset.
    wait_ready();
`ifdef ALU_SEQ_MULDIV_EN
    in_valid = 1'b1; op = T_DIVU; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("abort_busy_out_valid", 64'(out_valid), 64'd0);
`else
    out_ready = 1'b0;
    in_valid = 1'b1; op = T_ADD; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_done_out_valid", 64'(out_valid), 64'd1);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rst_in_ready",  64'(in_ready),  64'd0);
    chk("abort_rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("abort_in_ready_after", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      seen |= out_valid;
      @(posedge clk); #1;
    end
    chk("abort_no_out_valid", 64'(seen), 64'd0);
    run_and_check("abort_add", T_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);

    // Random operations against the reference model.
    for (int k = 0; k < 150; k++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = (k % 5 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (k % 17 == 0) rb = '0;
      model(ro, ra, rb, er, ez, eo, eil);
      run_and_check($sformatf("rnd%0d_op%0d", k, ro), ro, ra, rb, er, ez, eo, eil);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
